// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings, data width and line levels.
// Used by the transmitter, the receiver and the baud tick generator.
package uart_pkg;

  // Frame states; the receiver walks the same sequence.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned uart_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-boundary tick generator.
// Ports:
//   i_CLK   - clock, rising edge
//   i_RST_N - asynchronous active-low reset
//   i_EN    - count while high; counter is held at 0 while low
//   o_TICK  - high on the last clock of each CLKS_PER_BIT-long bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_EN,
  output logic o_TICK
);

  localparam int unsigned            CNT_W = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]       LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Strobe is combinational so the consumer can act on the same edge the count wraps.
  assign o_TICK = i_EN && (cnt_q == LAST);

  // Count 0..CLKS_PER_BIT-1, reload on every boundary, hold 0 when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_EN || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits, STOP_BITS stop bits on an idle-high line.
// Ports:
//   i_CLK      - clock, rising edge
//   i_RST_N    - asynchronous active-low reset
//   i_TX_VALID - request to send i_DATA
//   i_DATA     - byte to send, captured only on acceptance
//   o_TX_READY - high in IDLE; accept when i_TX_VALID && o_TX_READY
//   o_TX       - registered serial line
//   o_TX_BUSY  - high from the cycle after acceptance through the last stop cycle
//   o_TX_DONE  - one-cycle pulse in the first IDLE cycle after STOP
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_TX_VALID,
  input  logic [7:0] i_DATA,
  output logic       o_TX_READY,
  output logic       o_TX,
  output logic       o_TX_BUSY,
  output logic       o_TX_DONE
);

  localparam int unsigned         STOP_W    = 1;
  localparam logic [STOP_W-1:0]   STOP_LAST = STOP_W'(STOP_BITS - 1);
  localparam logic [2:0]          IDX_LAST  = 3'(UART_DATA_BITS - 1);
  localparam bit                  MSB       = (MSB_FIRST != 0);

  uart_state_e        state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [STOP_W-1:0]  stop_cnt_q, stop_cnt_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               baud_tick;
  logic               next_bit;
  logic [7:0]         shift_adv;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .i_CLK   (i_CLK),
    .i_RST_N (i_RST_N),
    .i_EN    (state_q != IDLE),
    .o_TICK  (baud_tick)
  );

  // Bit presented next and the register after it has been consumed.
  assign next_bit  = MSB ? shift_q[7] : shift_q[0];
  assign shift_adv = MSB ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d    = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (i_TX_VALID && ready_q) begin
          state_d    = START;
          shift_d    = i_DATA;
          bit_idx_d  = '0;
          stop_cnt_d = '0;
          tx_d       = UART_START_LEVEL;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end

      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = next_bit;
          shift_d   = shift_adv;
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d    = STOP;
            stop_cnt_d = '0;
            tx_d       = UART_IDLE_LEVEL;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = next_bit;
            shift_d   = shift_adv;
          end
        end
      end

      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d    = IDLE;
            stop_cnt_d = '0;
            bit_idx_d  = '0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end
        end
      end

      default: begin
        state_d    = IDLE;
        bit_idx_d  = '0;
        stop_cnt_d = '0;
        tx_d       = UART_IDLE_LEVEL;
        ready_d    = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // Reset drives the line idle immediately, truncating any frame in flight.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_TX       = tx_q;
  assign o_TX_READY = ready_q;
  assign o_TX_BUSY  = busy_q;
  assign o_TX_DONE  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a default instance (a_*) and a
// CLKS_PER_BIT=4 / STOP_BITS=2 / LSB-first instance (b_*).
// Cycle n of a frame is the value the DUT presents to its n-th edge after
// acceptance; it is sampled on the falling edge just before that edge.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_valid, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_tx, b_busy, b_done;
  logic [7:0] b_data;

  int         n_checks = 0;
  int         n_pass   = 0;

  int         cyc;
  logic       cap_tx    [0:63];
  logic       cap_done  [0:63];
  logic       cap_busy  [0:63];
  logic       cap_ready [0:63];

  always #5 clk = ~clk;

  uart_transmitter u_dut_a (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_TX_VALID (a_valid),
    .i_DATA     (a_data),
    .o_TX_READY (a_ready),
    .o_TX       (a_tx),
    .o_TX_BUSY  (a_busy),
    .o_TX_DONE  (a_done)
  );

  uart_transmitter #(
    .CLKS_PER_BIT (4),
    .STOP_BITS    (2),
    .MSB_FIRST    (0)
  ) u_dut_b (
    .i_CLK      (clk),
    .i_RST_N    (rst_n),
    .i_TX_VALID (b_valid),
    .i_DATA     (b_data),
    .o_TX_READY (b_ready),
    .o_TX       (b_tx),
    .o_TX_BUSY  (b_busy),
    .o_TX_DONE  (b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cap_a();
    cap_tx[cyc]    = a_tx;
    cap_done[cyc]  = a_done;
    cap_busy[cyc]  = a_busy;
    cap_ready[cyc] = a_ready;
  endtask

  // Begin a frame on DUT A at the current falling edge: cycle 0 is captured.
  task automatic start_a(input logic [7:0] d);
    cyc = 0;
    cap_a();
    a_valid = 1'b1;
    a_data  = d;
  endtask

  task automatic step_a();
    @(negedge clk);
    cyc++;
    cap_a();
  endtask

  // Reassemble an MSB-first byte whose first data bit sits at cycle 'first'.
  function automatic logic [7:0] decode_msb(input int first);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = cap_tx[first+k];
    return r;
  endfunction

  initial begin
    logic [10:0] exp_a5;
    logic        exp_b;
    int          n_done;

    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_data  = 8'h00;
    b_valid = 1'b0;
    b_data  = 8'h00;

    // Reset values.
    #22;
    check("rst_a_tx",    a_tx,    1);
    check("rst_a_ready", a_ready, 1);
    check("rst_a_busy",  a_busy,  0);
    check("rst_a_done",  a_done,  0);
    check("rst_b_tx",    b_tx,    1);
    check("rst_b_ready", b_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, default parameters: start, 1010_0101, stop, idle.
    exp_a5 = 11'b0_10100101_1_1;
    start_a(8'hA5);
    for (int c = 1; c <= 12; c++) begin
      step_a();
      if (c == 1) a_valid = 1'b0;
    end
    check("a5_ready0", cap_ready[0], 1);
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("a5_tx@%0d", c),   cap_tx[c],   exp_a5[11-c]);
      check($sformatf("a5_done@%0d", c), cap_done[c], (c == 11));
      check($sformatf("a5_busy@%0d", c), cap_busy[c], (c <= 10));
    end
    check("a5_ready@11", cap_ready[11], 1);
    check("a5_done@12",  cap_done[12],  0);
    check("a5_loopback", decode_msb(2), 8'hA5);

    // 0x01, C=4, S=2, LSB first.
    b_valid = 1'b1;
    b_data  = 8'h01;
    check("b_ready0", b_ready, 1);
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 1) b_valid = 1'b0;
      exp_b = ((c >= 5) && (c <= 8)) || (c >= 37);
      check($sformatf("b_tx@%0d", c),   b_tx,   exp_b);
      check($sformatf("b_done@%0d", c), b_done, (c == 45));
      check($sformatf("b_busy@%0d", c), b_busy, (c <= 44));
    end

    // Back-to-back 0x3C then 0xC3 with valid held high.
    start_a(8'h3C);
    for (int c = 1; c <= 23; c++) begin
      step_a();
      if (c == 1)  a_data  = 8'hC3;
      if (c == 12) a_valid = 1'b0;
    end
    check("b2b_tx@10",    cap_tx[10],    1);
    check("b2b_done@11",  cap_done[11],  1);
    check("b2b_ready@11", cap_ready[11], 1);
    check("b2b_busy@11",  cap_busy[11],  0);
    check("b2b_tx@12",    cap_tx[12],    0);
    check("b2b_busy@12",  cap_busy[12],  1);
    check("b2b_ready@12", cap_ready[12], 0);
    check("b2b_byte0",    decode_msb(2),  8'h3C);
    check("b2b_byte1",    decode_msb(13), 8'hC3);
    check("b2b_tx@21",    cap_tx[21],    1);
    check("b2b_done@22",  cap_done[22],  1);
    check("b2b_done@23",  cap_done[23],  0);

    // Valid pulsed with 0xFF during a 0x00 frame is ignored.
    start_a(8'h00);
    for (int c = 1; c <= 14; c++) begin
      step_a();
      if (c == 1) a_valid = 1'b0;
      if (c == 3) begin
        a_valid = 1'b1;
        a_data  = 8'hFF;
      end
      if (c == 4) a_valid = 1'b0;
    end
    n_done = 0;
    for (int c = 1; c <= 14; c++) if (cap_done[c]) n_done++;
    check("busyreq_ready@3", cap_ready[3], 0);
    check("busyreq_byte",    decode_msb(2), 8'h00);
    check("busyreq_tx@10",   cap_tx[10],   1);
    check("busyreq_done@11", cap_done[11], 1);
    check("busyreq_ndone",   n_done,       1);
    check("busyreq_tx@12",   cap_tx[12],   1);
    check("busyreq_busy@12", cap_busy[12], 0);

    // Reset asserted on cycle 5 of a 0x00 frame.
    start_a(8'h00);
    for (int c = 1; c <= 5; c++) begin
      step_a();
      if (c == 1) a_valid = 1'b0;
    end
    check("rstmid_tx_before", cap_tx[5], 0);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx",    a_tx,    1);
    check("rstmid_ready", a_ready, 1);
    check("rstmid_busy",  a_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (a_done) n_done++;
    end
    check("rstmid_no_done", n_done, 0);
    check("rstmid_idle_tx", a_tx,   1);

    start_a(8'h5A);
    for (int c = 1; c <= 12; c++) begin
      step_a();
      if (c == 1) a_valid = 1'b0;
    end
    check("after_rst_tx@1",   cap_tx[1],     0);
    check("after_rst_byte",   decode_msb(2), 8'h5A);
    check("after_rst_tx@10",  cap_tx[10],    1);
    check("after_rst_done@11", cap_done[11], 1);
    check("after_rst_done@12", cap_done[12], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises one 8-bit byte per request onto a single idle-high line as start bit, 8 data bits and 1–2 stop bits. It is the transmit counterpart of `uart_receiver`. With default parameters it emits one bit per clock, MSB first, so its output can drive `uart_receiver.i_RX` directly in loopback. A parameterised clock divider allows real baud rates.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal values are ≥1.
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 or 2.
- `MSB_FIRST`, default 1: 1 sends `i_DATA[7]` first, 0 sends `i_DATA[0]` first.

Ports:
- `i_CLK` in, 1: the single clock; all logic is on the rising edge.
- `i_RST_N` in, 1: asynchronous, active-low reset.
- `i_TX_VALID` in, 1: request to send `i_DATA`.
- `i_DATA` in, 8: byte to send; sampled only on acceptance.
- `o_TX_READY` out, 1: high only in IDLE; a byte is accepted when `i_TX_VALID && o_TX_READY`.
- `o_TX` out, 1: serial line; registered; idles high.
- `o_TX_BUSY` out, 1: high from the cycle after acceptance through the last stop-bit cycle.
- `o_TX_DONE` out, 1: one-cycle pulse; frame completed.

## Operation
- Reset values: `o_TX`=1, `o_TX_READY`=1, `o_TX_BUSY`=0, `o_TX_DONE`=0, state=IDLE, all counters 0, shift register 0.
- States and transitions:
  - IDLE → START on acceptance; `i_DATA` is copied into the shift register.
  - START: `o_TX`=0 for `CLKS_PER_BIT` cycles, then → DATA.
  - DATA: 8 bits, each held `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7. After index 7 completes → STOP.
  - STOP: `o_TX`=1 for `STOP_BITS*CLKS_PER_BIT` cycles, then → IDLE.
- Bit order:
  - `MSB_FIRST`=1: shift left and send bit 7.
  - `MSB_FIRST`=0: shift right and send bit 0.
- Baud counter: width `max(1,$clog2(CLKS_PER_BIT))`. It counts 0..`CLKS_PER_BIT`-1, reloads to 0 on every bit boundary, and is held at 0 in IDLE.
- `o_TX_DONE` pulses in the first IDLE cycle after STOP. `o_TX_READY` is high in that same cycle, so a new byte may be accepted there.
- Data stability: changes to `i_DATA` after acceptance do not affect the frame in flight.
- Requests while busy: `i_TX_VALID` while `o_TX_READY`=0 is ignored. Nothing is queued, and the requester must hold valid until ready.
- Reset mid-frame:
  - `o_TX` returns to 1 asynchronously and the frame is truncated.
  - No `o_TX_DONE` pulse is produced.
  - The next accepted byte produces a complete frame.
- There are no illegal-state lockups: unused state encodings go to IDLE with `o_TX`=1.

## Timing
- Acceptance edge is cycle 0. With C=`CLKS_PER_BIT` and S=`STOP_BITS`:
  - Start bit on `o_TX`: cycles 1..C.
  - Data bit k (k=0..7): cycles 1+C(k+1) .. C(k+2).
  - Stop: cycles 9C+1 .. (9+S)C.
  - `o_TX_DONE`=1 and ready=1: cycle (9+S)C+1.
- Minimum frame-to-frame period: (9+S)·C+1 cycles. With defaults this is 11 cycles, which satisfies `uart_receiver`: it needs its STOP cycle plus one IDLE cycle before the next start bit.
- `o_TX_BUSY` is high exactly on cycles 1..(9+S)C.
- Latency from acceptance to first line transition: 1 cycle.

## Structure
- Shared package `uart_pkg`:
  - State encodings IDLE/START/DATA/STOP, reused by the receiver.
  - Constant `UART_DATA_BITS`=8.
  - Line levels `UART_IDLE_LEVEL`=1 and `UART_START_LEVEL`=0.
- One sub-module: `uart_baud_tick` (parameter `CLKS_PER_BIT`, inputs `i_CLK`/`i_RST_N`/`i_EN`, output `o_TICK`). It generates bit-boundary ticks and is reused later by an oversampling receiver.
- The shift register, bit index and stop counter stay in `uart_transmitter`.

## Test plan
- Defaults, send 0xA5:
  - `o_TX` on cycles 1..11 must read 0,1,0,1,0,0,1,0,1,1,1.
  - `o_TX_DONE` is high on cycle 11 only.
  - Loopback into `uart_receiver` yields `o_DATA`=0xA5 with `o_RX_DONE`=1.
- `CLKS_PER_BIT`=4, `STOP_BITS`=2, `MSB_FIRST`=0, send 0x01:
  - Start low on cycles 1–4, bit0 high on cycles 5–8, bits 1–7 low on cycles 9–36, stop high on cycles 37–44.
  - Done on cycle 45.
- Back-to-back 0x3C then 0xC3 with valid held high:
  - Second acceptance occurs on the done cycle (11).
  - Second start bit on cycle 12.
  - No extra idle cycles; both bytes received correctly.
- Valid pulsed and `i_DATA` changed to 0xFF on cycle 3 of a 0x00 frame:
  - The request is ignored, and the line still carries 0x00.
  - Exactly one done pulse.
- `i_RST_N` low on cycle 5 of a frame:
  - `o_TX`=1 and ready=1 immediately; no done pulse.
  - After release, 0x5A transmits correctly.
